// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; one quotient bit per cycle, MSB first.
module ex_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic               div_annul,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_ready,
  output logic               div_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_q;
  logic               rneg_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic               busy_q;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               bit_ok;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Trial subtract is WIDTH+1 bits wide so its MSB is the borrow/sign.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    bit_ok  = ~diff[WIDTH];
    rem_nxt = bit_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], bit_ok};
    quo_fix = neg_q  ? (~quo_nxt + One) : quo_nxt;
    rem_fix = rneg_q ? (~rem_nxt + One) : rem_nxt;
    a_mag   = (div_signed && dividend[WIDTH-1]) ? (~dividend + One) : dividend;
    b_mag   = (div_signed && divisor[WIDTH-1])  ? (~divisor + One)  : divisor;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (div_annul) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_start) begin
            busy_q <= 1'b1;
            if (divisor != '0) begin
              state_q <= StRun;
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              neg_q   <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              rneg_q  <= div_signed & dividend[WIDTH-1];
            end else begin
              state_q <= StZero;
            end
          end
        end
        StZero: begin
          state_q  <= StDone;
          busy_q   <= 1'b0;
          result_q <= '0;
        end
        StRun: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            result_q <= {rem_fix, quo_fix};
          end
        end
        StDone: begin
          // Ready rises one cycle after entry; leaving requires start to drop.
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (!div_start) begin
            ready_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_result = result_q;
  assign div_ready  = ready_q;
  assign div_busy   = busy_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: scoreboard of expected {rem, quo} per accepted op.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_busy;

  int n_checks;
  int n_fail;
  logic [63:0] sb[$];

  ex_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_annul  (div_annul),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_result (div_result),
    .div_ready  (div_ready),
    .div_busy   (div_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Drives a request; returns #1 after the accepting edge, operands then scrambled.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_ready(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = div_busy ? 1 : 0;
    while (!div_ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (div_busy) busy_cnt++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    div_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (div_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", div_ready);
    end
    n_checks++;
    if (div_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", div_busy);
    end
    n_checks++;
    if (div_result !== 64'd0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", div_result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu();
    int lat, bc;
    logic [63:0] exp;
    sb.push_back(model(1'b0, 32'd100, 32'd7));
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(lat, bc);
    exp = sb.pop_front();
    n_checks++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL divu_latency: got %0d want 33", lat);
    end
    n_checks++;
    if (bc !== 32) begin
      n_fail++; $display("FAIL divu_busy_cycles: got %0d want 32", bc);
    end
    n_checks++;
    if (div_result !== exp || exp !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL divu_result: got %h want %h", div_result, {32'd2, 32'd14});
    end
    finish_op();
  endtask

  task automatic test_div_signed();
    logic [31:0] a_tab[3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] b_tab[3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [63:0] want[3]  = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                              {32'hFFFF_FFFF, 32'd3}};
    for (int i = 0; i < 3; i++) begin
      int lat, bc;
      logic [63:0] exp;
      sb.push_back(want[i]);
      start_op(1'b1, a_tab[i], b_tab[i]);
      wait_ready(lat, bc);
      exp = sb.pop_front();
      n_checks++;
      if (div_result !== exp) begin
        n_fail++; $display("FAIL div_signed_%0d: got %h want %h", i, div_result, exp);
      end
      finish_op();
    end
  endtask

  task automatic test_div_zero();
    for (int s = 0; s < 2; s++) begin
      int lat, bc;
      logic [63:0] exp;
      sb.push_back(model(s[0], 32'd1234, 32'd0));
      start_op(s[0], 32'd1234, 32'd0);
      wait_ready(lat, bc);
      exp = sb.pop_front();
      n_checks++;
      if (lat !== 2) begin
        n_fail++; $display("FAIL div_zero_latency_%0d: got %0d want 2", s, lat);
      end
      n_checks++;
      if (bc !== 1) begin
        n_fail++; $display("FAIL div_zero_busy_%0d: got %0d want 1", s, bc);
      end
      n_checks++;
      if (div_result !== exp) begin
        n_fail++; $display("FAIL div_zero_result_%0d: got %h want %h", s, div_result, exp);
      end
      finish_op();
    end
  endtask

  task automatic test_boundary();
    logic        s_tab[2] = '{1'b1, 1'b0};
    logic [31:0] a_tab[2] = '{32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b_tab[2] = '{32'hFFFF_FFFF, 32'd1};
    logic [63:0] want[2]  = '{{32'd0, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}};
    for (int i = 0; i < 2; i++) begin
      int lat, bc;
      logic [63:0] exp;
      sb.push_back(model(s_tab[i], a_tab[i], b_tab[i]));
      start_op(s_tab[i], a_tab[i], b_tab[i]);
      wait_ready(lat, bc);
      exp = sb.pop_front();
      n_checks++;
      if (div_result !== exp || exp !== want[i]) begin
        n_fail++; $display("FAIL boundary_%0d: got %h want %h", i, div_result, want[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_annul();
    int lat, bc;
    logic [63:0] exp;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    div_annul = 1'b1;
    div_start = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
      n_fail++; $display("FAIL annul_run: got ready=%b busy=%b want 0 0", div_ready, div_busy);
    end
    // Annul together with start in IDLE must not accept.
    @(negedge clk);
    div_signed = 1'b0;
    dividend   = 32'd9;
    divisor    = 32'd3;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (div_busy !== 1'b0) begin
      n_fail++; $display("FAIL annul_with_start: got busy=%b want 0", div_busy);
    end
    @(negedge clk);
    div_annul = 1'b0;
    sb.push_back(model(1'b0, 32'd9, 32'd3));
    @(posedge clk);
    #1;
    wait_ready(lat, bc);
    exp = sb.pop_front();
    n_checks++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL annul_fresh_latency: got %0d want 33", lat);
    end
    n_checks++;
    if (div_result !== exp || exp !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL annul_fresh_result: got %h want %h", div_result, {32'd0, 32'd3});
    end
    finish_op();
  endtask

  task automatic test_hold_done();
    int lat, bc;
    logic [63:0] exp;
    sb.push_back(model(1'b0, 32'd1000, 32'd33));
    start_op(1'b0, 32'd1000, 32'd33);
    wait_ready(lat, bc);
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (div_ready !== 1'b1 || div_result !== exp) begin
        n_fail++;
        $display("FAIL hold_done_%0d: got ready=%b res=%h want 1 %h", i, div_ready, div_result,
                 exp);
      end
    end
    finish_op();
    n_checks++;
    if (div_ready !== 1'b0 || div_result !== exp) begin
      n_fail++; $display("FAIL hold_release: got ready=%b res=%h want 0 %h", div_ready,
                         div_result, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    start_op(1'b0, 32'd5000, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (div_busy !== 1'b0 || div_ready !== 1'b0 || div_result !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid_run: got busy=%b ready=%b res=%h want 0 0 0",
                         div_busy, div_ready, div_result);
    end
    @(negedge clk);
    div_start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (div_busy !== 1'b0 || div_ready !== 1'b0 || div_result !== 64'd0) begin
      n_fail++; $display("FAIL reset_release: got busy=%b ready=%b res=%h want 0 0 0",
                         div_busy, div_ready, div_result);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int lat, bc;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      sgn = i[0];
      a   = $urandom;
      b   = (i == 3) ? 32'd0 : ($urandom >> (i * 3));
      sb.push_back(model(sgn, a, b));
      start_op(sgn, a, b);
      wait_ready(lat, bc);
      exp = sb.pop_front();
      n_checks++;
      if (lat !== ((b == 32'd0) ? 2 : 33)) begin
        n_fail++; $display("FAIL b2b_latency_%0d: got %0d", i, lat);
      end
      n_checks++;
      if (div_result !== exp) begin
        n_fail++; $display("FAIL b2b_result_%0d: got %h want %h (a=%h b=%h s=%b)", i,
                           div_result, exp, a, b, sgn);
      end
      finish_op();
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    n_checks   = 0;
    n_fail     = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_boundary();
    test_annul();
    test_hold_done();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
